// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: the in-order pipeline writeback has priority, and MDU results
// wait in a small FIFO whose stale entries are killed by younger pipeline writes.
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_addr,
  input  logic [31:0]   pipe_data,
  input  logic [31:0]   pipe_pc,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [4:0]    mdu_addr,
  input  logic [31:0]   mdu_data,
  input  logic [31:0]   mdu_pc,
  input  logic [4:0]    q_addr,
  output logic          q_hit,
  output logic [AW:0]   fifo_count,
  output logic          WE,
  output logic [4:0]    WriteAddr,
  output logic [31:0]   WData,
  output logic [31:0]   PC
);

  logic          live_q [DEPTH];
  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;

  logic          push, pop, push_live;
  logic          wb_vld_p1;
  logic [4:0]    wb_addr_p1;
  logic [31:0]   wb_data_p1, wb_pc_p1;

  assign mdu_ready  = (count != (AW+1)'(DEPTH));
  assign push       = mdu_valid && mdu_ready;
  assign pop        = !pipe_we && (count != '0);
  // A same-cycle pipeline write to the same register is younger, so the entry is born dead.
  assign push_live  = !(pipe_we && (pipe_addr == mdu_addr) && (mdu_addr != 5'd0));
  assign fifo_count = count;

  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == q_addr) && (q_addr != 5'd0)) q_hit = 1'b1;
    end
  end

  // Control: pointers, occupancy and live bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) live_q[i] <= 1'b0;
    end else begin
      if (pipe_we && (pipe_addr != 5'd0)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (addr_q[i] == pipe_addr) live_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        live_q[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        live_q[tail] <= push_live;
        tail         <= tail + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= mdu_addr;
      data_q[tail] <= mdu_data;
      pc_q[tail]   <= mdu_pc;
    end
  end

  // Stage p1: registered GRF write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_vld_p1  <= 1'b0;
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
      wb_pc_p1   <= '0;
    end else if (pipe_we) begin
      wb_vld_p1  <= 1'b1;
      wb_addr_p1 <= pipe_addr;
      wb_data_p1 <= pipe_data;
      wb_pc_p1   <= pipe_pc;
    end else if (pop) begin
      wb_vld_p1 <= live_q[head];
      if (live_q[head]) begin
        wb_addr_p1 <= addr_q[head];
        wb_data_p1 <= data_q[head];
        wb_pc_p1   <= pc_q[head];
      end
    end else begin
      wb_vld_p1 <= 1'b0;
    end
  end

  assign WE        = wb_vld_p1;
  assign WriteAddr = wb_addr_p1;
  assign WData     = wb_data_p1;
  assign PC        = wb_pc_p1;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_grf_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_we = 1'b0, mdu_valid = 1'b0;
  logic [4:0]  pipe_addr = '0, mdu_addr = '0, q_addr = '0;
  logic [31:0] pipe_data = '0, pipe_pc = '0, mdu_data = '0, mdu_pc = '0;
  logic        mdu_ready, q_hit, WE;
  logic [AW:0] fifo_count;
  logic [4:0]  WriteAddr;
  logic [31:0] WData, PC;

  grf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr),
    .mdu_data(mdu_data), .mdu_pc(mdu_pc),
    .q_addr(q_addr), .q_hit(q_hit), .fifo_count(fifo_count),
    .WE(WE), .WriteAddr(WriteAddr), .WData(WData), .PC(PC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0, m_pc = '0;
  int          total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we = 0; m_wa = 0; m_wd = 0; m_pc = 0;
  endtask

  // Reference behaviour for one rising edge, from the inputs held across it.
  task automatic model_edge();
    bit   do_push, do_pop;
    ent_t e;
    do_push = mdu_valid && (mq.size() != DEPTH);
    do_pop  = !pipe_we && (mq.size() != 0);
    if (pipe_we) begin
      m_we = 1; m_wa = pipe_addr; m_wd = pipe_data; m_pc = pipe_pc;
      foreach (mq[i]) if (pipe_addr != 0 && mq[i].addr == pipe_addr) mq[i].live = 0;
    end else if (do_pop) begin
      e = mq.pop_front();
      m_we = e.live;
      if (e.live) begin m_wa = e.addr; m_wd = e.data; m_pc = e.pc; end
    end else begin
      m_we = 0;
    end
    if (do_push) begin
      e.live = !(pipe_we && pipe_addr == mdu_addr && mdu_addr != 0);
      e.addr = mdu_addr; e.data = mdu_data; e.pc = mdu_pc;
      mq.push_back(e);
    end
  endtask

  task automatic compare_all();
    logic hit;
    hit = 0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == q_addr && q_addr != 0) hit = 1;
    chk("WE", 32'(WE), 32'(m_we));
    chk("WriteAddr", 32'(WriteAddr), 32'(m_wa));
    chk("WData", WData, m_wd);
    chk("PC", PC, m_pc);
    chk("mdu_ready", 32'(mdu_ready), 32'(mq.size() != DEPTH));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("q_hit", 32'(q_hit), 32'(hit));
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset(); else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    pipe_we = 0; mdu_valid = 0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    pipe_we = 1; pipe_addr = a; pipe_data = d; pipe_pc = p;
  endtask

  task automatic mdu(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    mdu_valid = 1; mdu_addr = a; mdu_data = d; mdu_pc = p;
  endtask

  initial begin
    model_reset();
    step(); step();
    chk("rst_WE", 32'(WE), 0);
    chk("rst_ready", 32'(mdu_ready), 1);
    chk("rst_count", 32'(fifo_count), 0);
    reset = 1;

    // Pipeline only
    pipe(5, 32'h1234, 32'h3000); step();
    chk("p_WE", 32'(WE), 1);
    chk("p_addr", 32'(WriteAddr), 5);
    chk("p_data", WData, 32'h1234);
    chk("p_pc", PC, 32'h3000);
    idle(); step();
    chk("p_idle_WE", 32'(WE), 0);

    // MDU path through an empty FIFO
    q_addr = 8;
    mdu(8, 32'hDEAD, 32'h3004); step();
    chk("m_qhit1", 32'(q_hit), 1);
    chk("m_cnt1", 32'(fifo_count), 1);
    chk("m_WE1", 32'(WE), 0);
    idle(); step();
    chk("m_WE2", 32'(WE), 1);
    chk("m_data2", WData, 32'hDEAD);
    chk("m_qhit2", 32'(q_hit), 0);
    chk("m_cnt2", 32'(fifo_count), 0);

    // Fill under pipeline pressure, then drain in order
    for (int i = 0; i < 4; i++) begin
      pipe(5'(10 + i), 32'h50 + 32'(i), 32'h4000);
      mdu(5'(16 + i), 32'h100 + 32'(i), 32'h5000 + 32'(i));
      q_addr = 5'(16 + i);
      step();
    end
    chk("f_ready", 32'(mdu_ready), 0);
    chk("f_cnt", 32'(fifo_count), 4);
    pipe(14, 32'h54, 32'h4000); mdu(20, 32'h999, 32'h6000); step();
    chk("f_cnt5", 32'(fifo_count), 4);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("d_WE", 32'(WE), 1);
      chk("d_addr", 32'(WriteAddr), 32'(16 + i));
      chk("d_data", WData, 32'h100 + 32'(i));
      if (i == 0) chk("d_ready", 32'(mdu_ready), 1);
    end
    step();
    chk("d_empty_WE", 32'(WE), 0);

    // Kill: queued reg 9 overtaken by a pipeline write
    q_addr = 9;
    pipe(1, 32'h77, 32'h3100); mdu(9, 32'h1, 32'h3104); step();
    chk("k_qhit_pre", 32'(q_hit), 1);
    idle(); pipe(9, 32'h2, 32'h3108); step();
    chk("k_data", WData, 32'h2);
    chk("k_addr", 32'(WriteAddr), 9);
    chk("k_qhit", 32'(q_hit), 0);
    chk("k_cnt", 32'(fifo_count), 1);
    idle(); step();
    chk("k_pop_WE", 32'(WE), 0);
    chk("k_cnt0", 32'(fifo_count), 0);

    // Same-edge conflict on reg 3
    q_addr = 3;
    pipe(3, 32'hBBBB, 32'h3200); mdu(3, 32'hAAAA, 32'h3204); step();
    chk("c_data", WData, 32'hBBBB);
    chk("c_cnt", 32'(fifo_count), 1);
    chk("c_qhit", 32'(q_hit), 0);
    idle(); step();
    chk("c_pop_WE", 32'(WE), 0);
    chk("c_data_hold", WData, 32'hBBBB);

    // Async reset with three entries queued
    pipe(1, 32'h11, 32'h3300);
    for (int i = 0; i < 3; i++) begin
      mdu(5'(21 + i), 32'h200 + 32'(i), 32'h3400); step();
    end
    chk("r_cnt_pre", 32'(fifo_count), 3);
    idle();
    #2 reset = 0;
    #1;
    chk("r_WE", 32'(WE), 0);
    chk("r_addr", 32'(WriteAddr), 0);
    chk("r_data", WData, 0);
    chk("r_pc", PC, 0);
    chk("r_cnt", 32'(fifo_count), 0);
    chk("r_ready", 32'(mdu_ready), 1);
    model_reset();
    step();
    reset = 1;
    q_addr = 22;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("r_after_WE", 32'(WE), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Write-side front end of the GRF. It merges two result producers onto the GRF's single write port (WE, WriteAddr, WData, PC).
- Producer 1 is the in-order main pipeline writeback. It has priority and no backpressure.
- Producer 2 is the multi-cycle MDU result path. It is buffered in a small FIFO with a valid/ready handshake.
- A query port reports registers with pending (not yet written) MDU results so the hazard unit can stall readers.

Parameters:
DEPTH, 4, MDU result FIFO depth in entries (power of two, 2..16)
AW, 2, log2(DEPTH), pointer width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
pipe_we  input  1  main pipeline writeback request this cycle
pipe_addr  input  5  destination register
pipe_data  input  32  write data
pipe_pc  input  32  PC of the writing instruction
mdu_valid  input  1  MDU result offered
mdu_ready  output  1  FIFO can accept (combinational from registered count: count != DEPTH)
mdu_addr  input  5  MDU destination register
mdu_data  input  32  MDU result
mdu_pc  input  32  PC of the MDU instruction
q_addr  input  5  register queried by the hazard unit
q_hit  output  1  a live FIFO entry targets q_addr (always 0 when q_addr == 0)
fifo_count  output  AW+1  current FIFO occupancy
WE  output  1  GRF write enable (registered)
WriteAddr  output  5  GRF write address (registered)
WData  output  32  GRF write data (registered)
PC  output  32  PC forwarded to the GRF for write logging (registered)

Behaviour:
- Reset (reset low, async): WE=0, WriteAddr=0, WData=0, PC=0.
- Reset also clears FIFO pointers, count and all entry live bits. Result: mdu_ready=1, q_hit=0, fifo_count=0.
- Reset mid-operation discards every queued entry; none is written.
- Entry format: {live, addr, data, pc}.
- MDU push: occurs when mdu_valid && mdu_ready. The entry is written at the tail and the tail increments (wraps mod DEPTH).
  - live=1 normally.
  - live=0 if pipe_we=1 in the same cycle with pipe_addr == mdu_addr. The pipeline write is treated as the younger one.
- Pipeline write: if pipe_we=1, the next cycle shows WE=1, WriteAddr=pipe_addr, WData=pipe_data, PC=pipe_pc. Latency is 1 cycle and the write is never delayed.
- Kill rule: when pipe_we=1, every live FIFO entry with addr == pipe_addr has live cleared in that same edge. A stale older MDU value never overwrites a newer pipeline value.
- Pop: occurs when pipe_we=0 and count != 0. The head is popped and the head pointer increments.
  - Head live=1: next cycle WE=1, WriteAddr/WData/PC taken from the head entry.
  - Head live=0: popped silently; next cycle WE=0.
- Idle: pipe_we=0 and count==0 gives WE=0 next cycle. WriteAddr/WData/PC hold their previous values.
- Simultaneous push and pop: both occur and count is unchanged. The ready decision uses the pre-edge count, so a full FIFO never accepts a push in the same cycle it pops.
- Empty-FIFO MDU path: minimum latency is 2 cycles (push edge, pop edge, output).
- Register $0: passed through unchanged; the GRF ignores it. The kill rule and q_hit never match address 0.
- q_hit: combinational OR over live entries of (addr == q_addr) && q_addr != 0.
- Ordering: FIFO entries drain in push order. Pipeline writes may overtake queued entries only under the kill rule above.

Test Plan:
- Pipeline only: reset, then pipe_we=1, addr=5, data=0x1234, pc=0x3000 → next cycle WE=1, WriteAddr=5, WData=0x1234, PC=0x3000; following idle cycle WE=0.
- MDU path: push addr=8, data=0xDEAD, pc=0x3004 with pipeline idle → q_hit(8)=1 and fifo_count=1 after edge 1; WE=1 with WData=0xDEAD after edge 2; q_hit(8)=0 and fifo_count=0 then.
- Full/backpressure: pipe_we held 1 with distinct addrs; push 4 MDU results → mdu_ready=0, count=4, 5th offer not accepted. Drop pipe_we → 4 consecutive MDU writes in push order, mdu_ready=1 after the first pop.
- Kill: queue addr=9 data=0x1 (pipeline busy), then pipeline writes addr=9 data=0x2 → GRF sees only 0x2 for reg 9. The killed pop cycle shows WE=0 and q_hit(9)=0 after the kill.
- Same-cycle conflict: mdu push addr=3 and pipe_we addr=3 in one edge → only the pipeline value is written; the entry drains silently.
- Async reset mid-operation: with 3 entries queued, pull reset low between clock edges → outputs 0 immediately, count=0. After release, no queued write ever appears.
